// File: rtl/gpu_pkg.sv
// Shared types and widths for the pixel framebuffer writer.
package gpu_pkg;

    localparam int unsigned COORD_W = 11;
    localparam int unsigned COLOR_W = 8;
    localparam int unsigned DROP_W  = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StClear = 2'd1,
        StRun   = 2'd2,
        StFlush = 2'd3
    } state_e;

    // Saturating increment for the drop counter.
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] value);
        return (&value) ? value : value + DROP_W'(1);
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO holding {address, colour} framebuffer writes.
// DEPTH must be a power of two so the pointers wrap naturally.
module pixel_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 29
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

    // Storage array; contents need no reset since empty gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/pixel_fb_writer.sv
// Pixel stream to framebuffer writer: bounds check, linear address stage,
// write FIFO and frame sequencing. Define PIXEL_FB_CLEAR_EN to include the
// background clear pass (CLEAR state writing BG_COLOR) before each frame.
module pixel_fb_writer
    import gpu_pkg::*;
#(
    parameter int unsigned        FIFO_DEPTH = 8,
    parameter int unsigned        ADDR_W     = 21,
    parameter logic [COLOR_W-1:0] BG_COLOR   = 8'h00
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COLOR_W-1:0] pix_color,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic               pix_valid,
    output logic               pix_ready,
    input  logic [COORD_W-1:0] width,
    input  logic [COORD_W-1:0] height,
    input  logic               frame_end,
    input  logic               draw,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [COLOR_W-1:0] fb_data,
    output logic               fb_we,
    input  logic               fb_ready,
    output logic               busy,
    output logic               frame_done,
    output logic [DROP_W-1:0]  drop_count
);

    localparam int unsigned ENTRY_W = ADDR_W + COLOR_W;
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned AREA_W  = 2 * COORD_W;
    localparam int unsigned LIN_W   = AREA_W + 1;

    state_e state_q, state_d;

    logic [COORD_W-1:0] w_q, h_q;
    logic               stage_valid_q;
    logic [ADDR_W-1:0]  stage_addr_q;
    logic [COLOR_W-1:0] stage_color_q;
    logic [DROP_W-1:0]  drop_q;

    logic               accept;
    logic               in_bounds;
    logic               draw_start;
    logic               clear_start;
    logic               clear_done;
    logic               flush_empty;
    logic [LIN_W-1:0]   lin_addr;

    logic               fifo_pop;
    logic [ENTRY_W-1:0] fifo_head;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ADDR_W-1:0]  head_addr;
    logic [COLOR_W-1:0] head_color;

    assign accept      = pix_valid && pix_ready;
    assign in_bounds   = (pix_x < w_q) && (pix_y < h_q);
    assign draw_start  = (state_q == StIdle) && draw;
    assign flush_empty = !stage_valid_q && fifo_empty;
    assign lin_addr    = LIN_W'(pix_y) * LIN_W'(w_q) + LIN_W'(pix_x);
    assign {head_addr, head_color} = fifo_head;
    // The FIFO only ever holds entries in RUN/FLUSH, so a non-empty head is a live write.
    assign fifo_pop    = !fifo_empty && fb_ready;
    assign drop_count  = drop_q;

`ifdef PIXEL_FB_CLEAR_EN
    logic [AREA_W-1:0] draw_area;
    logic [AREA_W-1:0] area_q;
    logic [AREA_W-1:0] clr_addr_q;

    assign draw_area   = AREA_W'(width) * AREA_W'(height);
    assign area_q      = AREA_W'(w_q) * AREA_W'(h_q);
    assign clear_start = (draw_area != '0);
    assign clear_done  = (state_q == StClear) && fb_ready && (clr_addr_q == area_q - AREA_W'(1));

    // Clear address walks 0..W*H-1, advancing only when a write completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_addr_q <= '0;
        end else if (state_q != StClear) begin
            clr_addr_q <= '0;
        end else if (fb_ready) begin
            clr_addr_q <= clr_addr_q + AREA_W'(1);
        end
    end
`else
    logic unused_bg_color;

    assign clear_start     = 1'b0;
    assign clear_done      = 1'b0;
    assign unused_bg_color = ^BG_COLOR;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; draw outside IDLE is ignored.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (draw) begin
                    state_d = clear_start ? StClear : StRun;
                end
            end
            StClear: begin
                if (clear_done) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (accept && frame_end) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                if (flush_empty) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode: handshake, write port and status.
    always_comb begin
        pix_ready  = 1'b0;
        fb_we      = 1'b0;
        fb_addr    = '0;
        fb_data    = '0;
        busy       = (state_q != StIdle);
        frame_done = 1'b0;
        unique case (state_q)
            StIdle: begin
            end
            StClear: begin
`ifdef PIXEL_FB_CLEAR_EN
                fb_we   = 1'b1;
                fb_addr = ADDR_W'(clr_addr_q);
                fb_data = BG_COLOR;
`endif
            end
            StRun: begin
                // Two slots of headroom cover the pixel sitting in the address stage.
                pix_ready = (fifo_count <= CNT_W'(FIFO_DEPTH - 2));
                if (!fifo_empty) begin
                    fb_we   = 1'b1;
                    fb_addr = head_addr;
                    fb_data = head_color;
                end
            end
            StFlush: begin
                if (!fifo_empty) begin
                    fb_we   = 1'b1;
                    fb_addr = head_addr;
                    fb_data = head_color;
                end
                frame_done = flush_empty;
            end
            default: begin
            end
        endcase
    end

    // Frame geometry latched on the accepted draw.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_q <= '0;
            h_q <= '0;
        end else if (draw_start) begin
            w_q <= width;
            h_q <= height;
        end
    end

    // Address stage: one cycle to form y*W + x for in-bounds pixels.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_valid_q <= 1'b0;
            stage_addr_q  <= '0;
            stage_color_q <= '0;
        end else begin
            stage_valid_q <= accept && in_bounds;
            if (accept && in_bounds) begin
                stage_addr_q  <= ADDR_W'(lin_addr);
                stage_color_q <= pix_color;
            end
        end
    end

    // Out-of-bounds pixel counter, cleared at frame start.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q <= '0;
        end else if (draw_start) begin
            drop_q <= '0;
        end else if (accept && !in_bounds) begin
            drop_q <= sat_inc(drop_q);
        end
    end

    // The ready threshold guarantees the stage never pushes into a full FIFO.
    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (stage_valid_q),
        .push_data ({stage_addr_q, stage_color_q}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    logic unused_fifo_full;
    assign unused_fifo_full = fifo_full;

endmodule

// File: tb/tb_pixel_fb_writer.sv
// Self-checking bench for pixel_fb_writer: table-driven single-pixel vectors,
// hand-written frame sequences and a random stream against a queue model.
module tb_pixel_fb_writer;

    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned ADDR_W     = 21;
    localparam int unsigned ADDR_MASK  = (1 << ADDR_W) - 1;
`ifdef PIXEL_FB_CLEAR_EN
    localparam int TH = 3;
`else
    localparam int TH = 480;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [7:0]        pix_color = '0;
    logic [10:0]       pix_x = '0;
    logic [10:0]       pix_y = '0;
    logic              pix_valid = 1'b0;
    logic              pix_ready;
    logic [10:0]       width = '0;
    logic [10:0]       height = '0;
    logic              frame_end = 1'b0;
    logic              draw = 1'b0;
    logic [ADDR_W-1:0] fb_addr;
    logic [7:0]        fb_data;
    logic              fb_we;
    logic              fb_ready = 1'b1;
    logic              busy;
    logic              frame_done;
    logic [15:0]       drop_count;

    pixel_fb_writer #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (ADDR_W),
        .BG_COLOR   (8'h00)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_color  (pix_color),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .width      (width),
        .height     (height),
        .frame_end  (frame_end),
        .draw       (draw),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .fb_we      (fb_we),
        .fb_ready   (fb_ready),
        .busy       (busy),
        .frame_done (frame_done),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned addr;
        int unsigned color;
    } wr_t;

    typedef struct {
        int unsigned x;
        int unsigned y;
        int unsigned color;
        bit          inb;
        int unsigned addr;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    wr_t exp_q[$];
    int  model_w = 0;
    int  model_h = 0;
    int  model_drop = 0;
    int  done_pulses = 0;
    int  ready_mode = 1;  // 0 stall, 1 always ready, 2 random

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // fb_ready driver, settles well before the negedge sample point.
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       fb_ready = 1'b0;
            1:       fb_ready = 1'b1;
            default: fb_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    // Scoreboard: observe handshakes just before the edge that completes them.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            model_drop = 0;
        end else begin
            if (fb_we && fb_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(fb_addr), 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("write_addr", 32'(fb_addr), e.addr);
                    check("write_data", 32'(fb_data), e.color);
                end
            end
            if (pix_valid && pix_ready) begin
                if (int'(pix_x) < model_w && int'(pix_y) < model_h) begin
                    wr_t e;
                    e.addr  = (int'(pix_y) * model_w + int'(pix_x)) & ADDR_MASK;
                    e.color = 32'(pix_color);
                    exp_q.push_back(e);
                end else if (model_drop < 16'hFFFF) begin
                    model_drop++;
                end
            end
            if (frame_done) done_pulses++;
        end
    end

    // All tasks start and end at posedge+1.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_draw(input int w, input int h);
        width   = 11'(w);
        height  = 11'(h);
        draw    = 1'b1;
        model_w = w;
        model_h = h;
        model_drop = 0;
`ifdef PIXEL_FB_CLEAR_EN
        for (int a = 0; a < w * h; a++) begin
            wr_t e;
            e.addr  = a & ADDR_MASK;
            e.color = 0;
            exp_q.push_back(e);
        end
`endif
        tick();
        draw = 1'b0;
    endtask

    task automatic wait_ready(input int max_cycles);
        bit ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (pix_ready) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        if (!ok) check("wait_ready_timeout", 0, 1);
    endtask

    task automatic send_pix(input int x, input int y, input int c, input bit fe);
        bit ok = 1'b0;
        pix_x = 11'(x);
        pix_y = 11'(y);
        pix_color = 8'(c);
        frame_end = fe;
        pix_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (pix_ready) ok = 1'b1;
            tick();
            if (ok) break;
        end
        pix_valid = 1'b0;
        frame_end = 1'b0;
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic load_pixel(input bit inb_only, input bit fe);
        if (!inb_only && $urandom_range(0, 4) == 0) begin
            pix_x = 11'(model_w + int'($urandom_range(0, 5)));
            pix_y = 11'($urandom_range(0, model_h - 1));
        end else begin
            pix_x = 11'($urandom_range(0, model_w - 1));
            pix_y = 11'($urandom_range(0, model_h - 1));
        end
        pix_color = 8'($urandom);
        frame_end = fe;
    endtask

    task automatic stream_n(input int n, input bit inb_only, input int max_cycles);
        int  sent = 0;
        int  cyc = 0;
        bit  acc;
        load_pixel(inb_only, n == 1);
        pix_valid = 1'b1;
        while (sent < n && cyc < max_cycles) begin
            @(negedge clk);
            acc = pix_ready;
            tick();
            cyc++;
            if (acc) begin
                sent++;
                if (sent < n) load_pixel(inb_only, sent == n - 1);
            end
        end
        pix_valid = 1'b0;
        frame_end = 1'b0;
        check("stream_accepted", sent, n);
    endtask

    task automatic stream_cycles(input int cycles, output int accepted);
        bit acc;
        accepted = 0;
        load_pixel(1'b1, 1'b0);
        pix_valid = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            acc = pix_ready;
            tick();
            if (acc) begin
                accepted++;
                load_pixel(1'b1, 1'b0);
            end
        end
        pix_valid = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        bit ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (frame_done) begin
                ok = 1'b1;
                check("writes_before_done", exp_q.size(), 0);
                tick();
                @(negedge clk);
                check("done_single_pulse", 32'(frame_done), 0);
                check("idle_after_done", 32'(busy), 0);
                tick();
                break;
            end
            tick();
        end
        if (!ok) check("frame_done_timeout", 0, 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int   exp_drops;
        int   accepted;
        int   done_before;
        int   frames = 0;

        vecs[0] = '{x: 3,    y: 2,      color: 'hA5, inb: 1'b1, addr: 1283};
        vecs[1] = '{x: 0,    y: 0,      color: 'h11, inb: 1'b1, addr: 0};
        vecs[2] = '{x: 639,  y: TH - 1, color: 'hFF, inb: 1'b1, addr: (TH - 1) * 640 + 639};
        vecs[3] = '{x: 640,  y: 0,      color: 'h22, inb: 1'b0, addr: 0};
        vecs[4] = '{x: 0,    y: TH,     color: 'h33, inb: 1'b0, addr: 0};
        vecs[5] = '{x: 100,  y: 1,      color: 'h3C, inb: 1'b1, addr: 740};
        vecs[6] = '{x: 2047, y: 2047,   color: 'h44, inb: 1'b0, addr: 0};

        // Reset state.
        tick();
        tick();
        @(negedge clk);
        check("rst_pix_ready", 32'(pix_ready), 0);
        check("rst_fb_we", 32'(fb_we), 0);
        check("rst_fb_addr", 32'(fb_addr), 0);
        check("rst_fb_data", 32'(fb_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_drop_count", 32'(drop_count), 0);
        tick();
        reset = 1'b0;
        tick();

`ifdef PIXEL_FB_CLEAR_EN
        // Clear pass over a 4x2 frame.
        do_draw(4, 2);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("clear_we", 32'(fb_we), 1);
            check("clear_addr", 32'(fb_addr), i);
            check("clear_data", 32'(fb_data), 0);
            tick();
        end
        @(negedge clk);
        check("clear_to_run", 32'(pix_ready), 1);
        tick();
        send_pix(1, 1, 'h5A, 1'b1);
        wait_done(50);
        frames++;
`else
        // Draw goes straight to RUN.
        do_draw(4, 2);
        @(negedge clk);
        check("draw_busy", 32'(busy), 1);
        check("draw_run_ready", 32'(pix_ready), 1);
        check("draw_no_clear_we", 32'(fb_we), 0);
        tick();
        send_pix(1, 1, 'h5A, 1'b1);
        wait_done(50);
        frames++;
`endif

        // Table-driven single pixels on a 640-wide frame: 2-cycle latency and drops.
        ready_mode = 1;
        do_draw(640, TH);
        wait_ready(3000);
        exp_drops = 0;
        for (int i = 0; i < 7; i++) begin
            send_pix(int'(vecs[i].x), int'(vecs[i].y), int'(vecs[i].color), 1'b0);
            @(negedge clk);
            check("addr_stage_no_we", 32'(fb_we), 0);
            tick();
            @(negedge clk);
            if (vecs[i].inb) begin
                check("vec_we", 32'(fb_we), 1);
                check("vec_addr", 32'(fb_addr), vecs[i].addr);
                check("vec_data", 32'(fb_data), vecs[i].color);
            end else begin
                exp_drops++;
                check("vec_drop_no_we", 32'(fb_we), 0);
                check("vec_drop_count", 32'(drop_count), exp_drops);
            end
            tick();
        end

        // Last pixel with the write port stalled for 5 cycles.
        ready_mode = 0;
        send_pix(5, 1, 'h77, 1'b1);
        @(negedge clk);
        check("flush_ready_low", 32'(pix_ready), 0);
        check("flush_busy", 32'(busy), 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("flush_stalled_no_done", 32'(frame_done), 0);
            tick();
        end
        ready_mode = 1;
        wait_done(20);
        frames++;

        // Backpressure then random stream with random fb_ready.
        do_draw(8 + int'($urandom_range(0, 56)), 2 + int'($urandom_range(0, 10)));
        wait_ready(2000);
        ready_mode = 0;
        stream_cycles(20, accepted);
        check("stall_accept_count", accepted, FIFO_DEPTH);
        @(negedge clk);
        check("stall_ready_low", 32'(pix_ready), 0);
        tick();
        ready_mode = 2;
        stream_n(40, 1'b0, 2000);
        wait_done(2000);
        frames++;
        check("random_drop_count", 32'(drop_count), model_drop);

        // Reset with writes queued abandons the frame.
        ready_mode = 1;
        do_draw(8, 8);
        wait_ready(500);
        ready_mode = 0;
        send_pix(1, 0, 'h01, 1'b0);
        send_pix(2, 3, 'h02, 1'b0);
        send_pix(7, 7, 'h03, 1'b0);
        tick();
        tick();
        done_before = done_pulses;
        reset = 1'b1;
        tick();
        @(negedge clk);
        check("midrun_rst_we", 32'(fb_we), 0);
        check("midrun_rst_busy", 32'(busy), 0);
        check("midrun_rst_done", 32'(frame_done), 0);
        check("midrun_rst_ready", 32'(pix_ready), 0);
        tick();
        reset = 1'b0;
        ready_mode = 1;
        for (int i = 0; i < 5; i++) tick();
        check("no_done_after_reset", done_pulses, done_before);
        do_draw(8, 8);
        wait_ready(500);
        send_pix(3, 4, 'hC3, 1'b0);
        send_pix(6, 1, 'h3C, 1'b1);
        wait_done(50);
        frames++;

        check("frame_done_total", done_pulses, frames);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_fb_writer.md
PIXEL_FB_WRITER -- requirements
Module: pixel_fb_writer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8: pixel FIFO entries, power of two, at least 4.
REQ-002 SHALL have parameter ADDR_W, default 21: framebuffer address width.
REQ-003 SHALL have parameter BG_COLOR, default 8'h00: colour written during clear.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have ports pix_color (in 8), pix_x (in 11), pix_y (in 11), pix_valid (in 1): upstream pixel stream.
REQ-007 SHALL have port pix_ready, output, 1: pixel accepted when pix_valid && pix_ready.
REQ-008 SHALL have ports width (in 11), height (in 11), frame_end (in 1), draw (in 1): frame geometry, last-pixel marker and frame-start pulse.
REQ-009 SHALL have ports fb_addr (out ADDR_W), fb_data (out 8), fb_we (out 1), fb_ready (in 1): framebuffer write port; a write completes on fb_we && fb_ready.
REQ-010 SHALL have ports busy (out 1), frame_done (out 1), drop_count (out 16): status.

Function
REQ-011 SHALL implement states IDLE, CLEAR, RUN, FLUSH.
REQ-012 IDLE, draw=1: SHALL latch width/height into W/H and go to CLEAR, or to RUN when the clear feature is compiled out or W*H=0.
REQ-013 draw in any state other than IDLE SHALL be ignored.
REQ-014 CLEAR: SHALL write BG_COLOR to addresses 0..W*H-1 in order, one address per write completion; fb_we held high with address/data stable while fb_ready=0; enters RUN the cycle after the write to W*H-1 completes.
REQ-015 pix_ready SHALL be 1 only in RUN with FIFO occupancy <= FIFO_DEPTH-2; pix_ready SHALL NOT depend combinationally on pix_valid.
REQ-016 An accepted pixel with pix_x<W and pix_y<H SHALL enter a 1-cycle address stage computing addr = pix_y*W + pix_x (unsigned, truncated to ADDR_W), then the FIFO.
REQ-017 An accepted pixel with pix_x>=W or pix_y>=H SHALL be discarded and SHALL increment drop_count, saturating at 16'hFFFF.
REQ-018 FIFO head SHALL drive fb_addr/fb_data with fb_we=1; pop on fb_we && fb_ready; with an empty FIFO and fb_ready=1, fb_we SHALL rise exactly 2 cycles after acceptance.
REQ-019 Pixel write order SHALL equal acceptance order; no pixel is lost or duplicated under any fb_ready pattern.
REQ-020 frame_end SHALL be sampled only on an accepted pixel (in or out of bounds); after that pixel the state SHALL go to FLUSH and pix_ready SHALL drop.
REQ-021 FLUSH: when the address stage and FIFO are empty and no write is pending, SHALL pulse frame_done for exactly 1 cycle and return to IDLE.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 drop_count SHALL clear on draw accepted in IDLE.

Reset
REQ-024 reset=1 SHALL, on the next edge, force IDLE, empty FIFO and address stage, and drive pix_ready=0, fb_we=0, fb_addr=0, fb_data=0, busy=0, frame_done=0, drop_count=0, W=H=0.
REQ-025 Reset mid-CLEAR, mid-RUN or mid-FLUSH SHALL abandon the in-flight writes with no frame_done pulse.

Configuration
REQ-026 With macro PIXEL_FB_CLEAR_EN defined, the CLEAR state and BG_COLOR writes SHALL be present; without it, CLEAR SHALL be absent, draw SHALL go straight to RUN, and BG_COLOR SHALL be unused.

Structure
REQ-027 Package gpu_pkg SHALL hold the state enum, coordinate width (11), colour width (8) and drop-counter width (16).
REQ-028 The FIFO SHALL be the sub-module pixel_fifo, parameterised by depth and entry width (ADDR_W+8), with push/pop/count/full/empty.

Verification
REQ-029 CLEAR_EN, draw with W=4,H=2, fb_ready=1 -> 8 writes of 8'h00 at addresses 0..7 on consecutive cycles, then RUN.
REQ-030 RUN, W=640: pixel (x=3,y=2,color=8'hA5) accepted at cycle t -> fb_we=1, fb_addr=1283, fb_data=8'hA5 at t+2.
REQ-031 fb_ready=0 for 20 cycles while streaming -> pix_ready falls at occupancy FIFO_DEPTH-1; after release all pixels are written in order with none lost.
REQ-032 Pixels (x=640,y=0) and (x=0,y=480) with W=640,H=480 -> no writes, drop_count=2.
REQ-033 Last pixel with frame_end=1 and fb_ready stalled 5 cycles -> frame_done single-cycle pulse after the final write, busy=0 the cycle after.
REQ-034 reset asserted mid-RUN with 3 pixels queued -> next cycle fb_we=0, busy=0, no frame_done; a following draw starts cleanly.
